// File: rtl/draw_pkg.sv
// Shared types and colour constants for the band sprite drawer.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;

endpackage

// File: rtl/span_calc.sv
// Clamped sprite span [lo, hi] around a centre column; never wraps below 0 or past the band edge.
module span_calc #(
    parameter int unsigned XW       = 8,
    parameter int unsigned HALF_W   = 2,
    parameter int unsigned SCREEN_W = 120
) (
    input  logic [XW-1:0] center,
    output logic [XW-1:0] lo,
    output logic [XW-1:0] hi
);

    localparam int unsigned    WW   = XW + 1;
    localparam logic [WW-1:0]  HALF = WW'(HALF_W);
    localparam logic [WW-1:0]  XMAX = WW'(SCREEN_W - 1);

    logic [WW-1:0] center_w;
    logic [WW-1:0] sum_w;

    // One extra bit of headroom keeps both the subtract and the add from wrapping
    always_comb begin
        center_w = {1'b0, center};
        sum_w    = center_w + HALF;
        lo       = (center_w >= HALF) ? XW'(center_w - HALF) : '0;
        hi       = (sum_w > XMAX) ? XW'(XMAX) : XW'(sum_w);
    end

endmodule

// File: rtl/band_sprite_drawer.sv
// Repaints a fixed-height screen band, one pixel per clock, drawing a solid bar sprite
// and clearing the rest; optionally limits the sweep to the old+new sprite columns.
module band_sprite_drawer
    import draw_pkg::*;
#(
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 7,
    parameter int unsigned SCREEN_W = 120,
    parameter int unsigned BAND_Y   = 112,
    parameter int unsigned BAND_H   = 3,
    parameter int unsigned HALF_W   = 2,
    parameter logic [2:0]  FG_COLOR = BLUE,
    parameter logic [2:0]  BG_COLOR = BLACK
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          dirty_only,
    input  logic [XW-1:0] position,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    color,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int unsigned     RYW   = (BAND_H > 1) ? $clog2(BAND_H) : 1;
    localparam logic [XW-1:0]   XMAX  = XW'(SCREEN_W - 1);
    localparam logic [RYW-1:0]  RYMAX = RYW'(BAND_H - 1);
    localparam logic [YW-1:0]   YTOP  = YW'(BAND_Y);

    state_e         state_q, state_d;
    logic [XW-1:0]  cx_q, cx_d;
    logic [RYW-1:0] ry_q, ry_d;
    logic [XW-1:0]  hi_q, hi_d;
    logic [XW-1:0]  nlo_q, nlo_d;
    logic [XW-1:0]  nhi_q, nhi_d;
    logic [XW-1:0]  plo_q, plo_d;
    logic [XW-1:0]  phi_q, phi_d;
    logic           pvalid_q, pvalid_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [2:0]     color_q, color_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [XW-1:0]  pos_clamped;
    logic [XW-1:0]  new_lo, new_hi;
    logic [XW-1:0]  sweep_lo, sweep_hi;

    assign pos_clamped = (position > XMAX) ? XMAX : position;

    span_calc #(
        .XW       (XW),
        .HALF_W   (HALF_W),
        .SCREEN_W (SCREEN_W)
    ) u_new_span (
        .center (pos_clamped),
        .lo     (new_lo),
        .hi     (new_hi)
    );

    function automatic logic [2:0] pix_color(input logic [XW-1:0] col,
                                             input logic [XW-1:0] slo,
                                             input logic [XW-1:0] shi);
        return (col >= slo && col <= shi) ? FG_COLOR : BG_COLOR;
    endfunction

    // Next-state, counter and registered-output logic; the pixel for the next cycle is loaded here
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        ry_d     = ry_q;
        hi_d     = hi_q;
        nlo_d    = nlo_q;
        nhi_d    = nhi_q;
        plo_d    = plo_q;
        phi_d    = phi_q;
        pvalid_d = pvalid_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sweep_lo = '0;
        sweep_hi = XMAX;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dirty_only && pvalid_q) begin
                        sweep_lo = (plo_q < new_lo) ? plo_q : new_lo;
                        sweep_hi = (phi_q > new_hi) ? phi_q : new_hi;
                    end
                    nlo_d   = new_lo;
                    nhi_d   = new_hi;
                    hi_d    = sweep_hi;
                    cx_d    = sweep_lo;
                    ry_d    = '0;
                    x_d     = sweep_lo;
                    y_d     = YTOP;
                    color_d = pix_color(sweep_lo, new_lo, new_hi);
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (cx_q == hi_q && ry_q == RYMAX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    if (ry_q == RYMAX) begin
                        cx_d = cx_q + XW'(1);
                        ry_d = '0;
                    end else begin
                        ry_d = ry_q + RYW'(1);
                    end
                    x_d     = cx_d;
                    y_d     = YTOP + YW'(ry_d);
                    color_d = pix_color(cx_d, nlo_q, nhi_q);
                    plot_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                plo_d    = nlo_q;
                phi_d    = nhi_q;
                pvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, span memory and outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            ry_q     <= '0;
            hi_q     <= '0;
            nlo_q    <= '0;
            nhi_q    <= '0;
            plo_q    <= '0;
            phi_q    <= '0;
            pvalid_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= BG_COLOR;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            ry_q     <= ry_d;
            hi_q     <= hi_d;
            nlo_q    <= nlo_d;
            nhi_q    <= nhi_d;
            plo_q    <= plo_d;
            phi_q    <= phi_d;
            pvalid_q <= pvalid_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/band_sprite_drawer.md
# band_sprite_drawer

Parametrised successor to the catcher renderer. Paints a horizontal sprite, a solid bar of `2*HALF_W+1` columns by `BAND_H` rows centred on an input x-position, into a fixed-height screen band. Every other band pixel is cleared to background, one pixel per clock, into the VGA adapter's plot interface. Adds a start/busy/done handshake, a plot strobe, position clamping, and a dirty-only mode that repaints just the union of the old and new sprite spans.

## Interface
Parameters:
- `XW`, 8: x coordinate width
- `YW`, 7: y coordinate width
- `SCREEN_W`, 120: band width in pixels; columns `0..SCREEN_W-1`
- `BAND_Y`, 112: top row of band
- `BAND_H`, 3: band height in rows, ≥1
- `HALF_W`, 2: sprite half-width; sprite is `2*HALF_W+1` columns
- `FG_COLOR`, 3'b001: sprite colour
- `BG_COLOR`, 3'b000: erase colour

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request a repaint; sampled only in IDLE
- `dirty_only`  in  1  mode, sampled with `start`: 0 = full band sweep, 1 = union of previous and new spans only
- `position`  in  XW  sprite centre x, sampled with `start`
- `x`  out  XW  pixel x
- `y`  out  YW  pixel y
- `color`  out  3  pixel colour
- `plot`  out  1  `x`/`y`/`color` valid this cycle
- `busy`  out  1  high from the cycle after an accepted `start` through the last plot
- `done`  out  1  one-cycle pulse after the last plot

## Operation
- States are IDLE, SWEEP and DONE.
- IDLE with `start`=1:
  - Latch `pc = min(position, SCREEN_W-1)`.
  - Compute new span `nlo = max(pc-HALF_W, 0)` and `nhi = min(pc+HALF_W, SCREEN_W-1)`. Use XW+1-bit arithmetic; no underflow wrap.
- Sweep range:
  - Full mode, or `prev_valid`=0: `lo=0`, `hi=SCREEN_W-1`.
  - Dirty-only with `prev_valid`=1: `lo=min(plo,nlo)`, `hi=max(phi,nhi)`.
- Go to SWEEP with `cx=lo` and `ry=0`.
- SWEEP, column-major:
  - Each cycle output `x=cx`, `y=BAND_Y+ry`, `plot=1`.
  - `color = FG_COLOR` if `nlo ≤ cx ≤ nhi`, else `BG_COLOR`.
  - `ry` increments; at `BAND_H-1` it wraps to 0 and `cx` increments.
  - After the plot at (`hi`, `BAND_H-1`), go to DONE.
- DONE, one cycle:
  - `done=1`, `plot=0`.
  - Update `plo←nlo`, `phi←nhi`, `prev_valid←1`.
  - Return to IDLE.
- `start` outside IDLE is ignored, not queued.

## Timing
- Reset values:
  - `x=0`, `y=0`, `color=BG_COLOR`, `plot=0`, `busy=0`, `done=0`.
  - State IDLE, `prev_valid=0`, `plo=phi=0`.
- Latency: the first plot is registered in the cycle after `start` is accepted. Plots are back-to-back, one per cycle, with no gaps.
- Plot counts:
  - Full sweep: exactly `SCREEN_W*BAND_H` plot cycles.
  - Dirty-only: `(hi-lo+1)*BAND_H`.
- `done` is asserted the cycle after the last plot; `busy` falls in that same cycle. A new `start` is accepted the cycle after `done`.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronously). `prev_valid` clears, so the next repaint is always a full sweep.
- Position inputs may change freely while busy; only the latched values are used.

## Structure
- Package `draw_pkg`:
  - state enum `{IDLE, SWEEP, DONE}`
  - colour constants `BLACK=3'b000`, `BLUE=3'b001` (defaults for `FG_COLOR`/`BG_COLOR`)
- Sub-module `span_calc`: combinational; inputs are centre, HALF_W and SCREEN_W, outputs are the clamped `lo`/`hi`. It is instantiated once for the new span. `prev` is stored as registered lo/hi.
- One FSM, plus column/row counters and span registers, in the top module.

## Test plan
- Full sweep, defaults, `position`=60, `dirty_only`=0:
  - exactly 360 plots, x 0..119, y 112..114 cycling per column
  - FG only for x 58..62
  - `done` one cycle after the 360th plot
- Reset, then `dirty_only`=1, `position`=60 → full 360-plot sweep, because `prev_valid`=0.
- After that, `dirty_only`=1, `position`=64:
  - x 58..66, 27 plots
  - BG for x 58..61, FG for x 62..66
- `position`=0: FG for x 0..2 only. `position`=200: clamped to 119, FG for x 117..119 only. No wrap in either case.
- `start` pulsed mid-sweep → ignored; plot count unchanged; single `done`.
- `reset` low at plot 100:
  - `plot`/`busy` go to 0 that cycle
  - the next `dirty_only` repaint does a full 360-plot sweep
